// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if
// Single-requester data-bus interface between the MEM-stage access controller
// (master) and the data memory / interconnect (slave).
//   req    : request valid                    (master -> slave)
//   addr   : word-aligned byte address        (master -> slave)
//   we     : write enable                     (master -> slave)
//   wstrb  : byte strobes                     (master -> slave)
//   wdata  : lane-replicated store data       (master -> slave)
//   gnt    : request accepted this cycle      (slave -> master)
//   rvalid : response valid, one per grant    (slave -> master)
//   rdata  : read data                        (slave -> master)
//   err    : response error, with rvalid      (slave -> master)
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, addr, we, wstrb, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, addr, we, wstrb, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Turns one MEM-stage load/store into a req/gnt/rvalid transaction on the
// data bus, stalls the pipeline while it is outstanding, returns aligned and
// extended load data, and flags misaligned, illegal or faulted accesses.
//
// Optional feature: define MEMACC_TIMEOUT_EN to add a TIMEOUT_W-bit watchdog
// that aborts a transaction stuck in REQ/RESP with an acc_fault.
//
// Ports:
//   clk, cpurst       : clock, asynchronous active-high reset
//   mem_en/wr/addr/wdata/op/flush : EX/MEM access request and kill
//   bus               : data-bus master port (mem_access_ctrl_if)
//   memacc_stall      : hold IF..EX/MEM pipeline registers
//   ld_valid/ld_data  : load completion pulse and extended result
//   acc_misalign      : misaligned-access pulse
//   acc_fault         : illegal op, bus error or watchdog timeout pulse
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int TIMEOUT_W = 8
) (
    input  logic               clk,
    input  logic               cpurst,
    input  logic               mem_en,
    input  logic               mem_wr,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_wdata,
    input  logic [2:0]         mem_op,
    input  logic               mem_flush,
    mem_access_ctrl_if.master  bus,
    output logic               memacc_stall,
    output logic               ld_valid,
    output logic [31:0]        ld_data,
    output logic               acc_misalign,
    output logic               acc_fault
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t               state, state_nxt;
    logic                 legal, aligned, start, busy, timeout, drop_eff;
    logic [3:0]           strb_d;
    logic [31:0]          wdata_d;
    logic [TIMEOUT_W-1:0] to_cnt;

    // Captured request; held stable on the bus until granted.
    logic [31:0]          addr_q, wdata_q, ld_data_q;
    logic [3:0]           strb_q;
    logic [2:0]           op_q;
    logic [1:0]           off_q;
    logic                 we_q, drop_q, err_q;

    logic [7:0]           rd_byte;
    logic [15:0]          rd_half;
    logic [31:0]          ld_ext;

    // Op legality, alignment and store lane formatting for the incoming access.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // case statements leaves it unassigned and infers a latch.
        legal   = 1'b0;
        aligned = 1'b1;
        strb_d  = 4'b1111;
        wdata_d = mem_wdata;
        case (mem_op)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = !mem_wr;
            default:                legal = 1'b0;
        endcase
        case (mem_op[1:0])
            2'b00: begin
                strb_d  = 4'b0001 << mem_addr[1:0];
                wdata_d = {4{mem_wdata[7:0]}};
            end
            2'b01: begin
                aligned = !mem_addr[0];
                strb_d  = 4'b0011 << {mem_addr[1], 1'b0};
                wdata_d = {2{mem_wdata[15:0]}};
            end
            2'b10:   aligned = (mem_addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        if (!mem_wr) begin
            strb_d = 4'b0000;
        end
    end

    assign start    = (state == IDLE) && mem_en && legal && aligned && !mem_flush;
    assign busy     = (state == REQ) || (state == RESP);
    assign timeout  = busy && (&to_cnt);
    assign drop_eff = drop_q || mem_flush;

`ifdef MEMACC_TIMEOUT_EN
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            to_cnt <= '0;
        end else if (start) begin
            to_cnt <= '0;
        end else if (busy) begin
            to_cnt <= to_cnt + TIMEOUT_W'(1);
        end
    end
`else
    // No watchdog: the counter is tied off so timeout never fires.
    assign to_cnt = '0;
`endif

    // Lane select and extension of the returned word using the captured offset.
    always_comb begin
        rd_byte = bus.rdata[{off_q, 3'b000} +: 8];
        rd_half = off_q[1] ? bus.rdata[31:16] : bus.rdata[15:0];
        case (op_q)
            3'b000:  ld_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  ld_ext = {24'h0, rd_byte};
            3'b101:  ld_ext = {16'h0, rd_half};
            default: ld_ext = bus.rdata;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge cpurst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of process order.
        if (cpurst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = REQ;
            REQ: begin
                if (timeout)        state_nxt = DONE;
                else if (bus.gnt)   state_nxt = RESP;
                else if (mem_flush) state_nxt = IDLE;
            end
            RESP: begin
                // The outstanding response is always absorbed before leaving.
                if (bus.rvalid)     state_nxt = drop_eff ? IDLE : DONE;
                else if (timeout)   state_nxt = DONE;
            end
            default:                state_nxt = IDLE;
        endcase
    end

    // Request capture, drop/error flags and load result.
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            op_q      <= '0;
            off_q     <= '0;
            we_q      <= 1'b0;
            drop_q    <= 1'b0;
            err_q     <= 1'b0;
            ld_data_q <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    addr_q  <= {mem_addr[31:2], 2'b00};
                    wdata_q <= wdata_d;
                    strb_q  <= strb_d;
                    op_q    <= mem_op;
                    off_q   <= mem_addr[1:0];
                    we_q    <= mem_wr;
                    drop_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
                REQ: begin
                    if (timeout)                     err_q  <= 1'b1;
                    else if (bus.gnt && mem_flush)   drop_q <= 1'b1;
                end
                RESP: begin
                    if (bus.rvalid) begin
                        err_q <= bus.err;
                        if (!drop_eff && !bus.err && !we_q) ld_data_q <= ld_ext;
                    end else begin
                        if (mem_flush) drop_q <= 1'b1;
                        if (timeout)   err_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs.
    always_comb begin
        bus.req      = (state == REQ) && !timeout;
        bus.addr     = addr_q;
        bus.we       = we_q;
        bus.wstrb    = strb_q;
        bus.wdata    = wdata_q;
        memacc_stall = 1'b0;
        case (state)
            IDLE:      memacc_stall = start;
            REQ, RESP: memacc_stall = 1'b1;
            default:   memacc_stall = 1'b0;
        endcase
        ld_valid     = (state == DONE) && !err_q && !we_q;
        ld_data      = ld_data_q;
        acc_misalign = (state == IDLE) && mem_en && legal && !aligned;
        acc_fault    = ((state == IDLE) && mem_en && !legal) || ((state == DONE) && err_q);
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
// Directed bench for mem_access_ctrl. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;
`ifdef MEMACC_TIMEOUT_EN
    localparam int TW = 4;
`else
    localparam int TW = 8;
`endif

    logic        clk = 1'b0;
    logic        cpurst;
    logic        mem_en, mem_wr, mem_flush;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  mem_op;
    logic        memacc_stall, ld_valid, acc_misalign, acc_fault;
    logic [31:0] ld_data;

    mem_access_ctrl_if bus_if ();

    mem_access_ctrl #(.TIMEOUT_W(TW)) dut (
        .clk          (clk),
        .cpurst       (cpurst),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_op       (mem_op),
        .mem_flush    (mem_flush),
        .bus          (bus_if),
        .memacc_stall (memacc_stall),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .acc_misalign (acc_misalign),
        .acc_fault    (acc_fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int stall_total = 0;
    int s0;

    always @(negedge clk) if (memacc_stall) stall_total++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] op,
                         input logic [31:0] wdata);
        mem_en    = 1'b1;
        mem_wr    = wr;
        mem_addr  = addr;
        mem_op    = op;
        mem_wdata = wdata;
    endtask

    initial begin
        cpurst = 1'b1;
        mem_en = 1'b0; mem_wr = 1'b0; mem_flush = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_op = '0;
        bus_if.gnt = 1'b0; bus_if.rvalid = 1'b0; bus_if.rdata = '0; bus_if.err = 1'b0;
        cyc(); cyc();
        @(negedge clk);
        check("rst_req",   32'(bus_if.req), 32'd0);
        check("rst_stall", 32'(memacc_stall), 32'd0);
        check("rst_ldv",   32'(ld_valid), 32'd0);
        check("rst_lddata", ld_data, 32'h0);
        check("rst_addr",  bus_if.addr, 32'h0);
        check("rst_fault", 32'(acc_fault), 32'd0);
        cyc();
        cpurst = 1'b0;
        cyc();

        // LB @0x1003, zero-wait bus.
        s0 = stall_total;
        issue(1'b0, 32'h0000_1003, 3'b000, 32'h0);
        @(negedge clk);
        check("lb_T_stall", 32'(memacc_stall), 32'd1);
        check("lb_T_req",   32'(bus_if.req), 32'd0);
        cyc(); bus_if.gnt = 1'b1;
        @(negedge clk);
        check("lb_req",  32'(bus_if.req), 32'd1);
        check("lb_addr", bus_if.addr, 32'h0000_1000);
        check("lb_we",   32'(bus_if.we), 32'd0);
        cyc(); bus_if.gnt = 1'b0; bus_if.rvalid = 1'b1; bus_if.rdata = 32'h8011_2233;
        @(negedge clk);
        check("lb_resp_req", 32'(bus_if.req), 32'd0);
        cyc(); bus_if.rvalid = 1'b0;
        @(negedge clk);
        check("lb_ldv",   32'(ld_valid), 32'd1);
        check("lb_data",  ld_data, 32'hFFFF_FF80);
        check("lb_done_stall", 32'(memacc_stall), 32'd0);
        cyc(); mem_en = 1'b0;
        @(negedge clk);
        check("lb_ldv_pulse", 32'(ld_valid), 32'd0);
        check("lb_stall_cycles", 32'(stall_total - s0), 32'd3);

        // SH @0x2002, grant delayed two cycles.
        cyc();
        s0 = stall_total;
        issue(1'b1, 32'h0000_2002, 3'b001, 32'h0000_ABCD);
        cyc();
        for (int i = 0; i < 3; i++) begin
            bus_if.gnt = (i == 2);
            @(negedge clk);
            check("sh_req",   32'(bus_if.req), 32'd1);
            check("sh_wstrb", 32'(bus_if.wstrb), 32'b1100);
            check("sh_wdata", bus_if.wdata, 32'hABCD_ABCD);
            check("sh_addr",  bus_if.addr, 32'h0000_2000);
            cyc();
        end
        bus_if.gnt = 1'b0; bus_if.rvalid = 1'b1; bus_if.rdata = 32'h0;
        cyc(); bus_if.rvalid = 1'b0;
        @(negedge clk);
        check("sh_ldv", 32'(ld_valid), 32'd0);
        check("sh_fault", 32'(acc_fault), 32'd0);
        cyc(); mem_en = 1'b0;
        @(negedge clk);
        check("sh_stall_cycles", 32'(stall_total - s0), 32'd5);
        check("sh_lddata_hold", ld_data, 32'hFFFF_FF80);

        // Misaligned LW, then illegal load op 011.
        cyc();
        issue(1'b0, 32'h0000_3001, 3'b010, 32'h0);
        @(negedge clk);
        check("mis_pulse", 32'(acc_misalign), 32'd1);
        check("mis_stall", 32'(memacc_stall), 32'd0);
        check("mis_fault", 32'(acc_fault), 32'd0);
        cyc();
        issue(1'b0, 32'h0000_3000, 3'b011, 32'h0);
        @(negedge clk);
        check("ill_fault", 32'(acc_fault), 32'd1);
        check("ill_mis",   32'(acc_misalign), 32'd0);
        check("ill_stall", 32'(memacc_stall), 32'd0);
        cyc(); mem_en = 1'b0;
        @(negedge clk);
        check("ill_req",   32'(bus_if.req), 32'd0);
        check("ill_pulse", 32'(acc_fault), 32'd0);

        // LHU @0x4002, flushed in RESP, response arrives later and is absorbed.
        cyc();
        issue(1'b0, 32'h0000_4002, 3'b101, 32'h0);
        cyc(); bus_if.gnt = 1'b1;
        cyc(); bus_if.gnt = 1'b0; mem_flush = 1'b1;
        cyc(); mem_flush = 1'b0; mem_en = 1'b0;
        @(negedge clk);
        check("fl_stall_wait", 32'(memacc_stall), 32'd1);
        cyc(); bus_if.rvalid = 1'b1; bus_if.rdata = 32'h1234_5678;
        cyc(); bus_if.rvalid = 1'b0;
        @(negedge clk);
        check("fl_ldv",   32'(ld_valid), 32'd0);
        check("fl_stall", 32'(memacc_stall), 32'd0);
        check("fl_lddata_hold", ld_data, 32'hFFFF_FF80);

        // LBU @0x4001 starts normally afterwards.
        cyc();
        issue(1'b0, 32'h0000_4001, 3'b100, 32'h0);
        cyc(); bus_if.gnt = 1'b1;
        cyc(); bus_if.gnt = 1'b0; bus_if.rvalid = 1'b1; bus_if.rdata = 32'h0000_A500;
        cyc(); bus_if.rvalid = 1'b0;
        @(negedge clk);
        check("lbu_ldv",  32'(ld_valid), 32'd1);
        check("lbu_data", ld_data, 32'h0000_00A5);
        cyc(); mem_en = 1'b0;

        // LH @0x5002: upper halfword, sign-extended.
        cyc();
        issue(1'b0, 32'h0000_5002, 3'b001, 32'h0);
        cyc(); bus_if.gnt = 1'b1;
        cyc(); bus_if.gnt = 1'b0; bus_if.rvalid = 1'b1; bus_if.rdata = 32'h8001_0000;
        cyc(); bus_if.rvalid = 1'b0;
        @(negedge clk);
        check("lh_data", ld_data, 32'hFFFF_8001);
        cyc(); mem_en = 1'b0;

        // SB @0x6001: single strobe, byte replicated.
        cyc();
        issue(1'b1, 32'h0000_6001, 3'b000, 32'h1234_56EF);
        cyc(); bus_if.gnt = 1'b1;
        @(negedge clk);
        check("sb_wstrb", 32'(bus_if.wstrb), 32'b0010);
        check("sb_wdata", bus_if.wdata, 32'hEFEF_EFEF);
        check("sb_we",    32'(bus_if.we), 32'd1);
        cyc(); bus_if.gnt = 1'b0; bus_if.rvalid = 1'b1;
        cyc(); bus_if.rvalid = 1'b0;
        cyc(); mem_en = 1'b0;

        // LW @0x7000 with bus error on the response.
        cyc();
        issue(1'b0, 32'h0000_7000, 3'b010, 32'h0);
        cyc(); bus_if.gnt = 1'b1;
        cyc(); bus_if.gnt = 1'b0; bus_if.rvalid = 1'b1; bus_if.err = 1'b1;
        bus_if.rdata = 32'hDEAD_BEEF;
        cyc(); bus_if.rvalid = 1'b0; bus_if.err = 1'b0;
        @(negedge clk);
        check("err_fault", 32'(acc_fault), 32'd1);
        check("err_ldv",   32'(ld_valid), 32'd0);
        check("err_lddata_hold", ld_data, 32'hFFFF_8001);
        cyc(); mem_en = 1'b0;
        @(negedge clk);
        check("err_pulse", 32'(acc_fault), 32'd0);

        // LW @0x9000 flushed in REQ before any grant.
        cyc();
        issue(1'b0, 32'h0000_9000, 3'b010, 32'h0);
        cyc(); mem_flush = 1'b1;
        @(negedge clk);
        check("flreq_req", 32'(bus_if.req), 32'd1);
        cyc(); mem_flush = 1'b0; mem_en = 1'b0;
        @(negedge clk);
        check("flreq_idle_req",   32'(bus_if.req), 32'd0);
        check("flreq_idle_stall", 32'(memacc_stall), 32'd0);

        // LW @0x8000, asynchronous reset in RESP, late rvalid ignored.
        cyc();
        issue(1'b0, 32'h0000_8000, 3'b010, 32'h0);
        cyc(); bus_if.gnt = 1'b1;
        cyc(); bus_if.gnt = 1'b0;
        #2;
        cpurst = 1'b1; mem_en = 1'b0;
        #1;
        check("arst_stall",  32'(memacc_stall), 32'd0);
        check("arst_lddata", ld_data, 32'h0);
        check("arst_addr",   bus_if.addr, 32'h0);
        cyc(); cpurst = 1'b0; bus_if.rvalid = 1'b1; bus_if.rdata = 32'hFFFF_FFFF;
        cyc(); bus_if.rvalid = 1'b0;
        @(negedge clk);
        check("arst_late_ldv",    32'(ld_valid), 32'd0);
        check("arst_late_lddata", ld_data, 32'h0);
        check("arst_late_stall",  32'(memacc_stall), 32'd0);

`ifdef MEMACC_TIMEOUT_EN
        // Grant never arrives: watchdog aborts with acc_fault.
        begin
            int  req_cycles;
            logic seen;
            req_cycles = 0;
            seen = 1'b0;
            cyc();
            issue(1'b0, 32'h0000_A000, 3'b010, 32'h0);
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (bus_if.req) req_cycles++;
                if (acc_fault) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("to_fault_seen", 32'(seen), 32'd1);
            check("to_req_cycles", 32'(req_cycles), 32'd15);
            check("to_stall_rel",  32'(memacc_stall), 32'd0);
            check("to_ldv",        32'(ld_valid), 32'd0);
            cyc(); mem_en = 1'b0;
            @(negedge clk);
            check("to_idle_req", 32'(bus_if.req), 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the data-memory port driven from the EX/MEM pipeline register outputs. It turns one MEM-stage load or store into a request/grant/response transaction on a single-requester data bus. While the transaction is pending it holds the pipeline through `memacc_stall`. It also returns aligned, sign- or zero-extended load data and reports misaligned, illegal or faulted accesses.

## Interface
- `TIMEOUT_W`, 8 — width of the watchdog counter; timeout fires at 2^TIMEOUT_W−1 cycles; used only with `MEMACC_TIMEOUT_EN`
- `clk` in 1 — core clock
- `cpurst` in 1 — reset, asynchronous, active-high
- `mem_en` in 1 — MEM-stage instruction is a load/store (from `ex2mem_mem_en_ffout`)
- `mem_wr` in 1 — 1 = store, 0 = load
- `mem_addr` in 32 — byte address
- `mem_wdata` in 32 — store data, right-aligned
- `mem_op` in 3 — funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `mem_flush` in 1 — kill the current access (trap or flush from later stage)
- `bus_req` out 1 — request valid
- `bus_addr` out 32 — word-aligned address (`addr[1:0]` = 0)
- `bus_we` out 1 — write enable
- `bus_wstrb` out 4 — byte strobes
- `bus_wdata` out 32 — lane-replicated store data
- `bus_gnt` in 1 — request accepted this cycle
- `bus_rvalid` in 1 — response valid; one per granted request, loads and stores
- `bus_rdata` in 32 — read data
- `bus_err` in 1 — response error, qualified by `bus_rvalid`
- `memacc_stall` out 1 — hold the IF..EX/MEM registers
- `ld_valid` out 1 — one-cycle pulse; `ld_data` valid
- `ld_data` out 32 — extended load result
- `acc_misalign` out 1 — one-cycle pulse, misaligned access
- `acc_fault` out 1 — one-cycle pulse: illegal op, bus error or timeout

## Operation
- **States:** IDLE, REQ, RESP, DONE. Reset state is IDLE.
- **Reset values:** all registered outputs are 0; request registers are 0.
- **Start condition:** `start = mem_en & legal & aligned & !mem_flush`.
- **Legal ops:**
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Any other op with `mem_en` → `acc_fault` pulse in the same cycle. No stall, no bus access.
- **Alignment:**
  - H/HU require `addr[0]` = 0.
  - W requires `addr[1:0]` = 0.
  - A violation with `mem_en` → `acc_misalign` pulse in the same cycle. No stall, no bus access.
- **IDLE:**
  - On `start`: capture addr, we, strobes, wdata, op and `addr[1:0]`; go to REQ.
  - `memacc_stall` = `start`, combinational.
  - `bus_rvalid` is ignored in IDLE.
- **REQ:**
  - `bus_req` = 1; address, we, strobes and wdata are held stable until `bus_gnt`.
  - `bus_gnt` → RESP.
  - `mem_flush` without `bus_gnt` → IDLE and drop the request.
  - `mem_flush` together with `bus_gnt` → RESP with the drop flag set.
- **RESP:**
  - `bus_req` = 0; wait for `bus_rvalid`.
  - `mem_flush` sets the drop flag; the outstanding response is always absorbed.
  - On `bus_rvalid`: if drop → IDLE; else → DONE.
- **DONE:**
  - `memacc_stall` = 0.
  - On error: `acc_fault` = 1.
  - Otherwise, for a load: `ld_valid` = 1.
  - Always → IDLE next cycle. The pipeline advances at the end of DONE, so the same instruction is never restarted.
- **`memacc_stall`:** equals `start` in IDLE; 1 in REQ and RESP; 0 in DONE.
- **Store strobes/data:**
  - SB: `wstrb = 0001 << a[1:0]`, data byte replicated ×4.
  - SH: `wstrb = 0011 << {a[1],0}`, halfword replicated ×2.
  - SW: 1111.
- **Load extraction:**
  - Select the byte at `a[1:0]` or the halfword at `a[1]` from `bus_rdata`, registered at `rvalid`.
  - Sign-extend for 000/001; zero-extend for 100/101.
  - `ld_data` holds its value until the next load completes.

## Timing
- Zero-wait bus (gnt in first REQ cycle, rvalid next cycle):
  - T: IDLE, start.
  - T+1: REQ/gnt.
  - T+2: RESP/rvalid.
  - T+3: DONE, `ld_valid`.
  - Stall is high for T..T+2, i.e. 3 cycles.
- Each extra gnt or rvalid wait cycle adds one stall cycle.
- `bus_gnt` and `bus_rvalid` may not both refer to the same request in one cycle. `rvalid` in REQ is ignored.
- `bus_gnt` asserted outside REQ is ignored.
- Async reset mid-transaction → IDLE immediately; late `rvalid` is discarded.
- Error/illegal/misalign pulses are exactly one cycle wide and mutually exclusive with `ld_valid`.

## Configuration
- **`MEMACC_TIMEOUT_EN` defined:**
  - A `TIMEOUT_W`-bit counter clears on entry to REQ and increments each cycle in REQ/RESP.
  - At all-ones: drop `bus_req`, go to DONE, pulse `acc_fault`, no `ld_valid`.
  - A late `rvalid` is then discarded in IDLE.
- **Undefined:** no counter; the controller waits indefinitely for `gnt`/`rvalid`, and `acc_fault` comes only from an illegal op or `bus_err`.

## Test plan
- LB at `0x1003`, zero-wait bus, `rdata=0x80112233` → `bus_addr=0x1000`, `ld_data=0xFFFFFF80` at T+3, stall 3 cycles.
- SH at `0x2002`, `wdata=0x0000ABCD`, gnt delayed 2 cycles → `bus_wstrb=1100`, `bus_wdata=0xABCDABCD` stable through REQ, stall 5 cycles.
- LW at `0x3001` → `acc_misalign` pulse at T, no `bus_req`, stall 0; op 011 load → `acc_fault` pulse, no `bus_req`.
- LHU with `mem_flush` in RESP, `rvalid` 2 cycles later → no `ld_valid`, back to IDLE, next access starts normally.
- LW with `bus_err` on rvalid → `acc_fault` at DONE, `ld_valid` = 0; `cpurst` asserted in RESP → outputs 0 asynchronously, late `rvalid` ignored.
- With `MEMACC_TIMEOUT_EN`, `TIMEOUT_W=4`, `gnt` never asserted → `acc_fault` after 15 cycles, `bus_req` drops, stall releases.
